// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned STALL_CW = 2;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STALL    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side hazard inputs and stall/flush controls for hazard_stall_controller.
// slave: the controller; master: the pipeline datapath driving it.
interface hazard_stall_controller_if #(
  parameter int unsigned REG_AW = hazard_pkg::REG_AW
);

  logic [REG_AW-1:0] IFID_Rs;
  logic [REG_AW-1:0] IFID_Rt;
  logic              IFID_Branch;
  logic              branch_taken;
  logic              IDEX_MemRead;
  logic              IDEX_RegWrite;
  logic [REG_AW-1:0] IDEX_Dst;
  logic              mem_req;
  logic              mem_ack;

  logic              PCWrite;
  logic              IFIDWrite;
  logic              IFID_Flush;
  logic              IDEX_Bubble;
  logic              EXMEM_Hold;
  logic              MEMWB_Bubble;
  logic              mem_err;

  modport slave (
    input  IFID_Rs, IFID_Rt, IFID_Branch, branch_taken,
           IDEX_MemRead, IDEX_RegWrite, IDEX_Dst, mem_req, mem_ack,
    output PCWrite, IFIDWrite, IFID_Flush, IDEX_Bubble,
           EXMEM_Hold, MEMWB_Bubble, mem_err
  );

  modport master (
    output IFID_Rs, IFID_Rt, IFID_Branch, branch_taken,
           IDEX_MemRead, IDEX_RegWrite, IDEX_Dst, mem_req, mem_ack,
    input  PCWrite, IFIDWrite, IFID_Flush, IDEX_Bubble,
           EXMEM_Hold, MEMWB_Bubble, mem_err
  );

endinterface

// File: rtl/hazard_stall_controller_mem_wait_timer.sv
// Memory-wait cycle counter with timeout compare. Counts freeze cycles of one
// data-memory access; saturates at MEM_TIMEOUT and never wraps.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_timeout
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] r_wait_cnt;
  logic          w_timeout;

  assign w_timeout = (r_wait_cnt == CW'(MEM_TIMEOUT));
  assign o_timeout = w_timeout;

  // Wait counter: start loads 1, clear on release, saturating increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= '0;
    end else if (i_start) begin
      r_wait_cnt <= CW'(1);
    end else if (i_clr) begin
      r_wait_cnt <= '0;
    end else if (i_inc && !w_timeout) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard/stall controller: load-use and branch-dependency stalls,
// taken-branch flush, and data-memory wait freezes with timeout.
// Optional feature macro: HAZARD_PERF_CNT_EN adds stall_cycles/freeze_cycles.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW      = hazard_pkg::REG_AW,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  hazard_stall_controller_if.slave    hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]                 stall_cycles,
  output logic [31:0]                 freeze_cycles
`endif
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [STALL_CW-1:0] r_stall_cnt;
  logic [STALL_CW-1:0] w_stall_cnt_nxt;
  logic                r_mem_err;

  logic [REG_AW-1:0]   w_dst;
  logic                w_dep;
  logic                w_lu;
  logic                w_bd;
  logic                w_frz;

  logic                w_freeze;
  logic                w_stall;
  logic                w_drop;
  logic                w_err_set;
  logic                w_tmr_start;
  logic                w_tmr_inc;
  logic                w_tmr_clr;
  logic                w_timeout;

  logic                w_pcwrite;
  logic                w_ifidwrite;
  logic                w_ifid_flush;
  logic                w_idex_bubble;
  logic                w_exmem_hold;
  logic                w_memwb_bubble;

  assign w_dst = hz.IDEX_Dst;
  assign w_dep = (w_dst != '0) && ((w_dst == hz.IFID_Rs) || (w_dst == hz.IFID_Rt));
  assign w_lu  = hz.IDEX_MemRead && w_dep;
  assign w_bd  = hz.IFID_Branch && hz.IDEX_RegWrite && w_dep;
  assign w_frz = hz.mem_req && !hz.mem_ack;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_tmr_start),
    .i_inc     (w_tmr_inc),
    .i_clr     (w_tmr_clr),
    .o_timeout (w_timeout)
  );

  // State, stall counter and sticky error register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_RUN;
      r_stall_cnt <= '0;
      r_mem_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
      if (w_err_set) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  // Next-state, timer control and pipeline control outputs.
  always_comb begin
    w_state_nxt     = r_state;
    w_stall_cnt_nxt = r_stall_cnt;
    w_freeze        = 1'b0;
    w_stall         = 1'b0;
    w_drop          = 1'b0;
    w_err_set       = 1'b0;
    w_tmr_start     = 1'b0;
    w_tmr_inc       = 1'b0;
    w_tmr_clr       = 1'b0;

    unique case (r_state)
      ST_RUN: begin
        if (w_frz) begin
          w_freeze    = 1'b1;
          w_tmr_start = 1'b1;
          w_state_nxt = ST_MEM_WAIT;
        end else if (w_lu || w_bd) begin
          w_stall = 1'b1;
          if (w_bd && hz.IDEX_MemRead) begin
            w_stall_cnt_nxt = STALL_CW'(1);
            w_state_nxt     = ST_STALL;
          end
        end
      end
      ST_STALL: begin
        if (w_frz) begin
          // stall_cnt is left untouched so the stall resumes after the access
          w_freeze    = 1'b1;
          w_tmr_start = 1'b1;
          w_state_nxt = ST_MEM_WAIT;
        end else begin
          w_stall         = 1'b1;
          w_stall_cnt_nxt = (r_stall_cnt == '0) ? '0 : r_stall_cnt - 1'b1;
          if (w_stall_cnt_nxt == '0) begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (hz.mem_ack || w_timeout) begin
          w_tmr_clr   = 1'b1;
          w_state_nxt = (r_stall_cnt != '0) ? ST_STALL : ST_RUN;
          if (!hz.mem_ack) begin
            w_drop    = 1'b1;
            w_err_set = 1'b1;
          end
        end else begin
          w_freeze  = 1'b1;
          w_tmr_inc = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase

    w_pcwrite      = 1'b1;
    w_ifidwrite    = 1'b1;
    w_ifid_flush   = 1'b0;
    w_idex_bubble  = 1'b0;
    w_exmem_hold   = 1'b0;
    w_memwb_bubble = 1'b0;

    // Controls are held at their defaults while reset is asserted, so an
    // in-flight mem_req cannot keep the pipeline frozen through reset.
    if (reset) begin
      if (w_freeze) begin
        w_pcwrite      = 1'b0;
        w_ifidwrite    = 1'b0;
        w_exmem_hold   = 1'b1;
        w_memwb_bubble = 1'b1;
      end else if (w_stall) begin
        w_pcwrite     = 1'b0;
        w_ifidwrite   = 1'b0;
        w_idex_bubble = 1'b1;
      end else begin
        w_ifid_flush   = hz.IFID_Branch && hz.branch_taken;
        w_memwb_bubble = w_drop;
      end
    end
  end

  assign hz.PCWrite      = w_pcwrite;
  assign hz.IFIDWrite    = w_ifidwrite;
  assign hz.IFID_Flush   = w_ifid_flush;
  assign hz.IDEX_Bubble  = w_idex_bubble;
  assign hz.EXMEM_Hold   = w_exmem_hold;
  assign hz.MEMWB_Bubble = w_memwb_bubble;
  assign hz.mem_err      = r_mem_err;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_freeze_cycles;
  logic        w_freeze_act;

  assign w_freeze_act = w_exmem_hold;

  // Performance counters: stalled cycles (PC held, no freeze) and freeze cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cycles  <= '0;
      r_freeze_cycles <= '0;
    end else begin
      if (!w_pcwrite && !w_freeze_act) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_freeze_act) begin
        r_freeze_cycles <= r_freeze_cycles + 32'd1;
      end
    end
  end

  assign stall_cycles  = r_stall_cycles;
  assign freeze_cycles = r_freeze_cycles;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed self-checking bench for hazard_stall_controller.
// Output vector order: {PCWrite,IFIDWrite,IFID_Flush,IDEX_Bubble,EXMEM_Hold,MEMWB_Bubble,mem_err}
module tb_hazard_stall_controller;

  localparam logic [6:0] DEF  = 7'b1100000;
  localparam logic [6:0] STL  = 7'b0001000;
  localparam logic [6:0] FRZ  = 7'b0000110;
  localparam logic [6:0] FLS  = 7'b1110000;
  localparam logic [6:0] DROP = 7'b1100010;
  localparam logic [6:0] ERR  = 7'b0000001;

  logic clk;
  logic reset;
  int unsigned n_checks;
  int unsigned n_fail;

  hazard_stall_controller_if #(.REG_AW(5)) hz_if ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] freeze_cycles;
`endif

  hazard_stall_controller #(
    .REG_AW      (5),
    .MEM_TIMEOUT (15)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz_if)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles  (stall_cycles),
    .freeze_cycles (freeze_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b expected=%b", tag, got[6:0], exp[6:0]);
    end
  endtask

  function automatic logic [6:0] outs();
    return {hz_if.PCWrite, hz_if.IFIDWrite, hz_if.IFID_Flush, hz_if.IDEX_Bubble,
            hz_if.EXMEM_Hold, hz_if.MEMWB_Bubble, hz_if.mem_err};
  endfunction

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic br,
                       input logic tk, input logic mr, input logic rw,
                       input logic [4:0] dst, input logic req, input logic ack);
    hz_if.IFID_Rs       = rs;
    hz_if.IFID_Rt       = rt;
    hz_if.IFID_Branch   = br;
    hz_if.branch_taken  = tk;
    hz_if.IDEX_MemRead  = mr;
    hz_if.IDEX_RegWrite = rw;
    hz_if.IDEX_Dst      = dst;
    hz_if.mem_req       = req;
    hz_if.mem_ack       = ack;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Check combinational outputs mid-cycle, then advance to just after the next edge.
  task automatic cyc(input string tag, input logic [6:0] exp);
    #2;
    check_eq(tag, {25'd0, outs()}, {25'd0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    idle();
    #12;
    check_eq("reset_state", {25'd0, outs()}, {25'd0, DEF});
    reset = 1'b1;
    @(posedge clk);
    #1;

    // 1: load r5 in EX, ID reads r5 -> single stall
    drive(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
    cyc("t1_stall", STL);
    drive(5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("t1_resume", DEF);

    // 2: load r5 in EX, beq on r5 in ID -> two stalls then flush
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
    cyc("t2_stall_run", STL);
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("t2_stall_st", STL);
    drive(5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("t2_flush", FLS);
    idle();
    cyc("t2_idle", DEF);

    // 3: r0 never stalls; ALU result feeding a branch -> one stall
    drive(5'd0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    cyc("t3_r0", DEF);
    drive(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
    cyc("t3_bd_stall", STL);
    drive(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("t3_bd_resume", DEF);

    // 4: ack after 3 freeze cycles, then a back-to-back access
    for (int i = 0; i < 3; i++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      cyc($sformatf("t4_freeze%0d", i), FRZ);
    end
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    cyc("t4_release", DEF);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    cyc("t4_b2b_freeze", FRZ);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    cyc("t4_b2b_release", DEF);
    idle();
    cyc("t4_no_err", DEF);

    // 5: no ack -> 15 freeze cycles, dropped release, sticky error
    for (int i = 0; i < 15; i++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      cyc($sformatf("t5_freeze%0d", i), FRZ);
    end
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    cyc("t5_drop", DROP);
    idle();
    cyc("t5_err_sticky", DEF | ERR);

    // 6: freeze during the load-to-branch STALL, stall resumes after ack
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
    cyc("t6_stall_run", STL | ERR);
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    cyc("t6_freeze", FRZ | ERR);
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    cyc("t6_release", DEF | ERR);
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("t6_stall_resume", STL | ERR);
    drive(5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("t6_flush", FLS | ERR);

    // Reset asserted mid-MEM_WAIT with the request still pending
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    cyc("rst_freeze0", FRZ | ERR);
    #2;
    check_eq("rst_freeze1", {25'd0, outs()}, {25'd0, FRZ | ERR});
    reset = 1'b0;
    #1;
    check_eq("rst_async", {25'd0, outs()}, {25'd0, DEF});
    idle();
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc("rst_run", DEF);
    drive(5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
    cyc("rst_then_stall", STL);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
